// File: rtl/maxnet_term_ctrl_pkg.sv
// Shared definitions for the MaxNet termination controller and the MaxNet top:
// FSM state encoding, index/counter width helper and default sizing.
package maxnet_term_ctrl_pkg;

   localparam int DEFAULT_N        = 4;
   localparam int DEFAULT_MAX_ITER = 16;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_CHECK = 3'd2,
      S_ITER  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   // Bits needed to encode values 0..v-1; never less than one bit.
   function automatic int idx_w(input int v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/maxnet_term_ctrl_if.sv
// Control/result bundle between the termination controller (master) and the
// MaxNet top level / datapath (slave).
interface maxnet_term_ctrl_if
   import maxnet_term_ctrl_pkg::*;
#(
   parameter int N = DEFAULT_N
) ();

   logic                  start;
   logic [N-1:0]          active;
   logic                  load;
   logic                  iter_en;
   logic                  busy;
   logic                  done;
   logic [idx_w(N)-1:0]   winner_idx;
   logic                  winner_valid;
   logic                  timeout;

   modport master (
      input  start, active,
      output load, iter_en, busy, done, winner_idx, winner_valid, timeout
   );

   modport slave (
      output start, active,
      input  load, iter_en, busy, done, winner_idx, winner_valid, timeout
   );

endinterface

// File: rtl/maxnet_term_ctrl_onehot_enc.sv
// Classifies the per-neuron activity flags: none set, exactly one set, and the
// index of the lowest set bit (only meaningful when exactly one is set).
module maxnet_onehot_enc
   import maxnet_term_ctrl_pkg::*;
#(
   parameter int N = DEFAULT_N
) (
   input  logic [N-1:0]          active,
   output logic                  is_zero,
   output logic                  is_onehot,
   output logic [idx_w(N)-1:0]   idx
);

   localparam int IDX_W = idx_w(N);

   // Zero / one-hot detection: clearing the lowest set bit leaves nothing.
   always_comb begin
      is_zero   = (active == '0);
      is_onehot = !is_zero && ((active & (active - N'(1))) == '0);
   end

   // Lowest set bit wins: scan from the top so lower indices overwrite.
   always_comb begin
      idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (active[i]) idx = IDX_W'(i);
      end
   end

endmodule

// File: rtl/maxnet_term_ctrl.sv
// MaxNet sequencing/termination controller. Loads the datapath, steps the
// inhibition iterations and stops on a single survivor, total suppression or
// an exhausted iteration budget. All outputs are registered.
module maxnet_term_ctrl
   import maxnet_term_ctrl_pkg::*;
#(
   parameter int N        = DEFAULT_N,
   parameter int MAX_ITER = DEFAULT_MAX_ITER
) (
   input  logic                 clk,
   input  logic                 rst_n,
   maxnet_term_ctrl_if.master   bus
);

   localparam int IDX_W = idx_w(N);
   localparam int CNT_W = idx_w(MAX_ITER + 1);

   state_t             state;
   logic [CNT_W-1:0]   iter_cnt;
   logic               enc_zero;
   logic               enc_onehot;
   logic [IDX_W-1:0]   enc_idx;

   maxnet_onehot_enc #(
      .N (N)
   ) u_enc (
      .active    (bus.active),
      .is_zero   (enc_zero),
      .is_onehot (enc_onehot),
      .idx       (enc_idx)
   );

   // Run sequencing: state, iteration count, strobes and held results.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= S_IDLE;
         iter_cnt         <= '0;
         bus.load         <= 1'b0;
         bus.iter_en      <= 1'b0;
         bus.busy         <= 1'b0;
         bus.done         <= 1'b0;
         bus.winner_idx   <= '0;
         bus.winner_valid <= 1'b0;
         bus.timeout      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  iter_cnt         <= '0;
                  bus.winner_idx   <= '0;
                  bus.winner_valid <= 1'b0;
                  bus.timeout      <= 1'b0;
                  bus.load         <= 1'b1;
                  bus.busy         <= 1'b1;
                  state            <= S_LOAD;
               end
            end
            S_LOAD: begin
               bus.load <= 1'b0;
               state    <= S_CHECK;
            end
            S_CHECK: begin
               // A survivor outranks the budget check in the same cycle.
               if (enc_onehot) begin
                  bus.winner_valid <= 1'b1;
                  bus.winner_idx   <= enc_idx;
                  bus.done         <= 1'b1;
                  state            <= S_DONE;
               end else if (enc_zero) begin
                  bus.winner_valid <= 1'b0;
                  bus.timeout      <= 1'b0;
                  bus.done         <= 1'b1;
                  state            <= S_DONE;
               end else if (iter_cnt == CNT_W'(MAX_ITER)) begin
                  bus.timeout <= 1'b1;
                  bus.done    <= 1'b1;
                  state       <= S_DONE;
               end else begin
                  bus.iter_en <= 1'b1;
                  state       <= S_ITER;
               end
            end
            S_ITER: begin
               bus.iter_en <= 1'b0;
               iter_cnt    <= iter_cnt + CNT_W'(1);
               state       <= S_CHECK;
            end
            S_DONE: begin
               bus.done <= 1'b0;
               bus.busy <= 1'b0;
               state    <= S_IDLE;
            end
            default: begin
               bus.load    <= 1'b0;
               bus.iter_en <= 1'b0;
               bus.done    <= 1'b0;
               bus.busy    <= 1'b0;
               state       <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_maxnet_term_ctrl.sv
// Directed bench for maxnet_term_ctrl at N=4, MAX_ITER=16. The bench plays the
// datapath: it presents active flags and switches them after a chosen number
// of iter_en pulses. Cycle 0 is the edge that samples start.
module tb_maxnet_term_ctrl;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   maxnet_term_ctrl_if #(.N(4)) bus ();

   maxnet_term_ctrl #(
      .N        (4),
      .MAX_ITER (16)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input int observed, input int expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Start a run from IDLE and follow it to the done pulse (bounded).
   task automatic run(input logic [3:0] pat0, input int sw, input logic [3:0] pat1,
                      input int repulse, output int done_cyc, output int n_iter,
                      output int load_cyc, output int busy_low);
      done_cyc   = -1;
      n_iter     = 0;
      load_cyc   = -1;
      busy_low   = 0;
      bus.active = (sw == 0) ? pat1 : pat0;
      bus.start  = 1'b1;
      tick();
      bus.start  = 1'b0;
      for (int cyc = 1; cyc < 100; cyc++) begin
         bus.start = (cyc == repulse);
         if (bus.load && load_cyc < 0) load_cyc = cyc;
         if (!bus.busy) busy_low++;
         if (bus.iter_en) begin
            n_iter++;
            if (n_iter >= sw) bus.active = pat1;
         end
         if (bus.done) begin
            done_cyc = cyc;
            break;
         end
         tick();
      end
      bus.start = 1'b0;
   endtask

   int done_cyc, n_iter, load_cyc, busy_low, iter_seen;

   initial begin
      checks    = 0;
      failures  = 0;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.active = 4'b0000;
      tick();
      tick();

      // Reset state
      check("rst_busy", bus.busy, 0);
      check("rst_load", bus.load, 0);
      check("rst_done", bus.done, 0);
      check("rst_wvalid", bus.winner_valid, 0);
      rst_n = 1'b1;
      tick();

      // Immediate winner
      run(4'b0100, 1000, 4'b0100, -1, done_cyc, n_iter, load_cyc, busy_low);
      check("imm_load_cyc", load_cyc, 1);
      check("imm_done_cyc", done_cyc, 3);
      check("imm_iters", n_iter, 0);
      check("imm_busy_low", busy_low, 0);
      check("imm_idx", bus.winner_idx, 2);
      check("imm_wvalid", bus.winner_valid, 1);
      check("imm_timeout", bus.timeout, 0);

      // Start raised in the DONE cycle: not taken until the next cycle
      bus.start  = 1'b1;
      bus.active = 4'b1000;
      tick();
      check("done_edge_busy", bus.busy, 0);
      check("done_edge_load", bus.load, 0);
      check("done_edge_done", bus.done, 0);
      tick();
      bus.start = 1'b0;
      check("late_start_load", bus.load, 1);
      tick();
      tick();
      check("late_start_done", bus.done, 1);
      check("late_start_idx", bus.winner_idx, 3);
      tick();

      // Iterative convergence, with a start re-pulsed mid-run
      run(4'b1011, 2, 4'b1000, 4, done_cyc, n_iter, load_cyc, busy_low);
      check("conv_done_cyc", done_cyc, 7);
      check("conv_iters", n_iter, 2);
      check("conv_idx", bus.winner_idx, 3);
      check("conv_wvalid", bus.winner_valid, 1);
      tick();
      check("conv_busy_after", bus.busy, 0);
      check("conv_done_pulse", bus.done, 0);
      tick();
      check("conv_no_queue", bus.load, 0);
      check("conv_held_idx", bus.winner_idx, 3);

      // Tie: everything suppressed
      run(4'b0110, 1, 4'b0000, -1, done_cyc, n_iter, load_cyc, busy_low);
      check("tie_done_cyc", done_cyc, 5);
      check("tie_wvalid", bus.winner_valid, 0);
      check("tie_timeout", bus.timeout, 0);
      tick();

      // Timeout
      run(4'b0011, 1000, 4'b0011, -1, done_cyc, n_iter, load_cyc, busy_low);
      check("to_done_cyc", done_cyc, 35);
      check("to_iters", n_iter, 16);
      check("to_timeout", bus.timeout, 1);
      check("to_wvalid", bus.winner_valid, 0);
      tick();

      // Winner appears on the final permitted check
      run(4'b0011, 16, 4'b0001, -1, done_cyc, n_iter, load_cyc, busy_low);
      check("last_done_cyc", done_cyc, 35);
      check("last_wvalid", bus.winner_valid, 1);
      check("last_timeout", bus.timeout, 0);
      check("last_idx", bus.winner_idx, 0);
      tick();

      // Asynchronous reset in the middle of ITER
      bus.active = 4'b0011;
      bus.start  = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      tick();
      check("mid_iter_en", bus.iter_en, 1);
      rst_n = 1'b0;
      #1;
      check("arst_iter_en", bus.iter_en, 0);
      check("arst_busy", bus.busy, 0);
      check("arst_wvalid", bus.winner_valid, 0);
      check("arst_idx", bus.winner_idx, 0);
      tick();
      rst_n = 1'b1;
      iter_seen = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (bus.iter_en || bus.busy) iter_seen++;
      end
      check("post_rst_quiet", iter_seen, 0);

      // Fresh run after the reset
      run(4'b1101, 3, 4'b0010, -1, done_cyc, n_iter, load_cyc, busy_low);
      check("fresh_done_cyc", done_cyc, 9);
      check("fresh_idx", bus.winner_idx, 1);
      check("fresh_wvalid", bus.winner_valid, 1);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
